// File: rtl/cid8b_pipe.sv
// cid8b_pipe: two-stage pipelined 8-bit subtractor with borrow-in and a
// valid/ready handshake on both sides.
//
// Stage 1 splits the subtraction into nibbles. The low nibble takes the
// borrow-in. The high nibble is computed with zero borrow-in, so neither
// nibble waits on the other. Stage 2 applies the low-nibble borrow to the
// high nibble with a decrementer and forms the final flags.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; discards in-flight beats
//   inA        minuend (unsigned or two's complement)
//   inB        subtrahend
//   bin        borrow-in
//   in_valid   operand beat offered
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   diff       (inA - inB - bin) mod 256
//   bout       unsigned borrow-out: 1 iff inA < inB + bin
//   ovf        two's-complement overflow of the subtraction
//   out_valid  result beat presented
//   out_ready  consumer accepts the result this cycle
module cid8b_pipe (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] inA,
   input  logic [7:0] inB,
   input  logic       bin,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] diff,
   output logic       bout,
   output logic       ovf,
   output logic       out_valid,
   input  logic       out_ready
);

   // stage valid flags
   logic       s1_v_q, s1_v_d;
   logic       s2_v_q, s2_v_d;

   // stage 1 registers: nibble differences, their borrows, operand signs
   logic [3:0] lo_q, lo_d;
   logic       b4_q, b4_d;
   logic [3:0] hi_q, hi_d;
   logic       bh_q, bh_d;
   logic       sa_q, sa_d;
   logic       sb_q, sb_d;

   // stage 2 (output) registers
   logic [7:0] diff_q, diff_d;
   logic       bout_q, bout_d;
   logic       ovf_q, ovf_d;

   logic       accept;
   logic       s1_adv;
   logic       s2_drain;
   logic [4:0] lo_full;
   logic [4:0] hi_full;
   logic [4:0] dec_full;

   // handshake
   always_comb begin
      s2_drain = s2_v_q & out_ready;
      // s1 may move forward when s2 is empty or is being emptied right now
      s1_adv   = s1_v_q & (~s2_v_q | out_ready);
      in_ready = ~s1_v_q | s1_adv;
      accept   = in_valid & in_ready;
      s1_v_d   = accept | (s1_v_q & ~s1_adv);
      s2_v_d   = s1_adv | (s2_v_q & ~s2_drain);
   end

   // ---- stage 1: nibble differences ----
   // 5-bit results: bit 4 is the nibble borrow (the value went negative)
   always_comb begin
      lo_full = {1'b0, inA[3:0]} - {1'b0, inB[3:0]} - {4'b0000, bin};
      hi_full = {1'b0, inA[7:4]} - {1'b0, inB[7:4]};
      lo_d = lo_q;
      b4_d = b4_q;
      hi_d = hi_q;
      bh_d = bh_q;
      sa_d = sa_q;
      sb_d = sb_q;
      if (accept) begin
         lo_d = lo_full[3:0];
         b4_d = lo_full[4];
         hi_d = hi_full[3:0];
         bh_d = hi_full[4];
         sa_d = inA[7];
         sb_d = inB[7];
      end
   end

   // ---- stage 2: apply low-nibble borrow to high nibble ----
   // The decrement can only wrap when the high difference is 0, in which case
   // the high nibble itself did not borrow, so bh and the wrap never both set.
   always_comb begin
      dec_full = {1'b0, hi_q} - {4'b0000, b4_q};
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      if (s1_adv) begin
         diff_d = {dec_full[3:0], lo_q};
         bout_d = bh_q | dec_full[4];
         // operand signs differ and result sign differs from the minuend
         ovf_d  = (sa_q ^ sb_q) & (dec_full[3] ^ sa_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         lo_q   <= 4'h0;
         b4_q   <= 1'b0;
         hi_q   <= 4'h0;
         bh_q   <= 1'b0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         diff_q <= 8'h00;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         lo_q   <= lo_d;
         b4_q   <= b4_d;
         hi_q   <= hi_d;
         bh_q   <= bh_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign out_valid = s2_v_q;

endmodule

// File: tb/tb_cid8b_pipe.sv
module tb_cid8b_pipe;

   logic       clk;
   logic       rst;
   logic [7:0] inA;
   logic [7:0] inB;
   logic       bin;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] diff;
   logic       bout;
   logic       ovf;
   logic       out_valid;
   logic       out_ready;

   int n_checks;
   int n_errors;

   cid8b_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .inA       (inA),
      .inB       (inB),
      .bin       (bin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: {bout, ovf, diff} from a plain 9-bit subtraction
   function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
      logic [8:0] f;
      logic [7:0] d;
      f = {1'b0, a} - {1'b0, b} - {8'h00, bi};
      d = f[7:0];
      return {f[8], (a[7] != b[7]) && (d[7] != a[7]), d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; inA = 8'h55; inB = 8'h11; bin = 1'b0; out_ready = 1'b1;
      tick(); tick();
      n_checks++;
      if ({out_valid, diff, bout, ovf} !== 11'h000) begin
         n_errors++;
         $display("FAIL reset_hold got v=%b d=%h b=%b o=%b exp all zero", out_valid, diff, bout, ovf);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_first got rdy=%b v=%b d=%h exp rdy=1 v=0 d=00", in_ready, out_valid, diff);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_no_accept got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      inA = 8'h50; inB = 8'h30; bin = 1'b0; in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_ready got %b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0; inA = 8'hAA; inB = 8'hBB;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_lat1 got v=%b exp 0", out_valid);
      end
      tick();
      n_checks++;
      if ({out_valid, diff, bout, ovf} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL basic_result got v=%b d=%h b=%b o=%b exp v=1 d=20 b=0 o=0", out_valid, diff, bout, ovf);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_one_cycle got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_arith();
      logic [7:0] ta [6] = '{8'h10, 8'h00, 8'h80, 8'h7F, 8'h00, 8'hFF};
      logic [7:0] tb [6] = '{8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00};
      logic       tc [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
      logic [7:0] ed [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h7F, 8'h00, 8'hFE};
      logic       eb [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
      logic       eo [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         inA = ta[i]; inB = tb[i]; bin = tc[i]; in_valid = 1'b1;
         tick();
         in_valid = 1'b0; inA = 8'h33; inB = 8'h44; bin = 1'b0;
         tick();
         n_checks++;
         if ({out_valid, diff, bout, ovf} !== {1'b1, ed[i], eb[i], eo[i]}) begin
            n_errors++;
            $display("FAIL arith_%0d got v=%b d=%h b=%b o=%b exp v=1 d=%h b=%b o=%b",
                     i, out_valid, diff, bout, ovf, ed[i], eb[i], eo[i]);
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] ta [4] = '{8'h50, 8'h10, 8'h80, 8'h00};
      logic [7:0] tb [4] = '{8'h30, 8'h01, 8'h01, 8'h01};
      logic [7:0] ed [4] = '{8'h20, 8'h0F, 8'h7F, 8'hFF};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin
            inA = ta[i]; inB = tb[i]; bin = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ready_%0d got %b exp 1", i, in_ready);
         end
         n_checks++;
         if (i >= 2 && i < 6) begin
            if (out_valid !== 1'b1 || diff !== ed[i-2]) begin
               n_errors++;
               $display("FAIL b2b_out_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, diff, ed[i-2]);
            end
         end else if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle_%0d got v=%b exp 0", i, out_valid);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      inA = 8'h50; inB = 8'h30; bin = 1'b0; in_valid = 1'b1;  // A
      tick();
      inA = 8'h10; inB = 8'h01;                               // B
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_accept_b got rdy=%b exp 1", in_ready);
      end
      tick();
      inA = 8'h80; inB = 8'h01;                               // C
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_full_ready got rdy=%b exp 0", in_ready);
      end
      n_checks++;
      if ({out_valid, diff} !== {1'b1, 8'h20}) begin
         n_errors++;
         $display("FAIL bp_hold_a got v=%b d=%h exp v=1 d=20", out_valid, diff);
      end
      tick();
      n_checks++;
      if ({out_valid, diff, bout, ovf} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL bp_stable got v=%b d=%h b=%b o=%b exp v=1 d=20 b=0 o=0", out_valid, diff, bout, ovf);
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_release_ready got rdy=%b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, diff} !== {1'b1, 8'h0F}) begin
         n_errors++;
         $display("FAIL bp_out_b got v=%b d=%h exp v=1 d=0f", out_valid, diff);
      end
      tick();
      n_checks++;
      if ({out_valid, diff, ovf} !== {1'b1, 8'h7F, 1'b1}) begin
         n_errors++;
         $display("FAIL bp_out_c got v=%b d=%h o=%b exp v=1 d=7f o=1", out_valid, diff, ovf);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_drained got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0;
      inA = 8'h99; inB = 8'h11; bin = 1'b0; in_valid = 1'b1;
      tick();
      inA = 8'h77; inB = 8'h22;
      tick();
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_full got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid);
      end
      rst = 1'b1; inA = 8'h66; inB = 8'h01;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, diff, bout, ovf} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL flush_after got v=%b rdy=%b d=%h b=%b o=%b exp v=0 rdy=1 zeros",
                  out_valid, in_ready, diff, bout, ovf);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_ghost_%0d got v=%b d=%h exp v=0", i, out_valid, diff);
         end
      end
   endtask

   task automatic test_random();
      logic [9:0] q[$];
      logic [9:0] exp_r;
      int         accepted;
      int         cycles;
      int         seen;
      accepted = 0;
      cycles   = 0;
      seen     = 0;
      while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
         if (accepted < 1000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            inA = 8'($urandom); inB = 8'($urandom); bin = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            in_valid = 1'b0;
            out_ready = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL rand_extra got d=%h with no beat outstanding", diff);
            end else begin
               exp_r = q.pop_front();
               if ({bout, ovf, diff} !== exp_r) begin
                  n_errors++;
                  $display("FAIL rand_%0d got b=%b o=%b d=%h exp b=%b o=%b d=%h",
                           seen, bout, ovf, diff, exp_r[9], exp_r[8], exp_r[7:0]);
               end
            end
            seen++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_sub(inA, inB, bin));
            accepted++;
         end
         tick();
         cycles++;
      end
      n_checks++;
      if (seen !== 1000 || q.size() != 0) begin
         n_errors++;
         $display("FAIL rand_count got %0d results, %0d pending exp 1000 results, 0 pending", seen, q.size());
      end
      in_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; inA = 8'h00; inB = 8'h00; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_arith();
      test_back_to_back();
      test_backpressure();
      test_reset_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
